text_scanner: RTL

Pixel-to-glyph scanner sitting directly upstream of the glyph bitmap ROM in the display path. Holds a small character buffer, converts the incoming raster position into a glyph code, glyph row and glyph column for the ROM, then consumes the ROM's combinational `dot` and emits a registered pixel with sync signals delayed to match. Also provides a host write port for the buffer and an optional blinking cursor.

---
 rtl/text_scanner.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/text_scanner.sv
`default_nettype none
// ============================================================================
// Module   : text_scanner
// Purpose  : Raster-to-glyph scanner with a flop character buffer feeding a
//            glyph ROM; optional blinking cursor via TEXT_SCANNER_CURSOR_EN.
// Revision : 1.0
// ============================================================================
module text_scanner #(
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    COLS         = 16,
  parameter int                    ROWS         = 4,
  parameter int                    X0           = 0,
  parameter int                    Y0           = 0,
  parameter logic [ADDR_WIDTH-1:0] BLANK_CODE   = '1,
  parameter int                    BLINK_FRAMES = 30,
  localparam int                   CELLS        = COLS * ROWS,
  localparam int                   CW           = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  de,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_addr,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic [CW-1:0]         cursor_addr,
  output logic [ADDR_WIDTH-1:0] char,
  output logic [2:0]            row,
  output logic [2:0]            col,
  input  logic                  dot,
  output logic                  pix,
  output logic                  de_o,
  output logic                  hsync_o,
  output logic                  vsync_o
);

  localparam logic [31:0] WIN_W = 32'(8 * COLS);
  localparam logic [31:0] WIN_H = 32'(8 * ROWS);

  logic [ADDR_WIDTH-1:0] buf_q [CELLS];

  logic [31:0]           x_rel;
  logic [31:0]           y_rel;
  logic [CW-1:0]         cell_idx;
  logic                  in_win;
  logic [ADDR_WIDTH-1:0] char_d, char_q;
  logic [2:0]            row_d, row_q;
  logic [2:0]            col_d, col_q;
  logic                  in_win_q;
  logic                  blank_q;
  logic                  de_q, hsync_q, vsync_q;
  logic                  cursor_term;
  logic                  pix_d, pix_q;
  logic                  de_o_q, hsync_o_q, vsync_o_q;

  // Below-origin positions wrap to huge unsigned values, so one compare per axis suffices.
  assign x_rel    = 32'(x) - 32'(X0);
  assign y_rel    = 32'(y) - 32'(Y0);
  assign in_win   = de && (x_rel < WIN_W) && (y_rel < WIN_H);
  assign cell_idx = CW'((y_rel >> 3) * 32'(COLS) + (x_rel >> 3));

  always_comb begin
    char_d = BLANK_CODE;
    row_d  = 3'd0;
    col_d  = 3'd0;
    if (in_win) begin
      char_d = buf_q[cell_idx];
      row_d  = y[2:0];
      col_d  = x[2:0];
    end
  end

  // clr outranks a coincident write; the read above sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < CELLS; i++) begin
        buf_q[i] <= BLANK_CODE;
      end
    end else if (wr_en && (32'(wr_addr) < 32'(CELLS))) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      char_q   <= BLANK_CODE;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      in_win_q <= 1'b0;
      blank_q  <= 1'b1;
      de_q     <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      char_q   <= char_d;
      row_q    <= row_d;
      col_q    <= col_d;
      in_win_q <= in_win;
      blank_q  <= (char_d == BLANK_CODE);
      de_q     <= de;
      hsync_q  <= hsync;
      vsync_q  <= vsync;
    end
  end

`ifdef TEXT_SCANNER_CURSOR_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_d, blink_cnt_q;
  logic          phase_d, phase_q;
  logic          vsync_prev_q;
  logic          hit_q;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (vsync && !vsync_prev_q) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      vsync_prev_q <= vsync;
      hit_q        <= in_win && (cell_idx == cursor_addr);
    end
  end

  assign cursor_term = phase_q & hit_q;
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_addr;
  assign cursor_term   = 1'b0;
`endif

  assign pix_d = (dot & in_win_q & ~blank_q) ^ cursor_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q     <= 1'b0;
      de_o_q    <= 1'b0;
      hsync_o_q <= 1'b0;
      vsync_o_q <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      de_o_q    <= de_q;
      hsync_o_q <= hsync_q;
      vsync_o_q <= vsync_q;
    end
  end

  assign char    = char_q;
  assign row     = row_q;
  assign col     = col_q;
  assign pix     = pix_q;
  assign de_o    = de_o_q;
  assign hsync_o = hsync_o_q;
  assign vsync_o = vsync_o_q;

endmodule
`default_nettype wire
